elevator_call_scheduler: RTL and testbench
==========================================

# elevator_call_scheduler

Call scheduler sitting in front of the 4-floor car-position FSM (ground, L1, L2, L3). Latches floor-call buttons and picks the next target with a SCAN (keep-direction) policy. Drives the FSM's one-hot floor command inputs, then sequences a timed door-open phase on arrival. Flags a fault if the car fails to reach its target within a timeout.

## Interface
- DOOR_CYCLES, 8: cycles door_open stays high per stop (≥2).
- MOVE_TIMEOUT, 64: max cycles in MOVE before FAULT (≥4).
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  clock enable. Low: all state except the input synchronizers holds.
- call_in  in  4  raw level-sensitive call buttons; bit i = floor i (0 = ground).
- car_floor  in  2  binary current floor reported by the position FSM.
- floor_cmd  out  4  one-hot target command to the position FSM; 0 = none.
- pending  out  4  latched outstanding calls.
- door_open  out  1  door-open phase active.
- dir_up  out  1  moving upward (MOVE only).
- dir_dn  out  1  moving downward (MOVE only).
- fault  out  1  move timeout occurred; sticky until reset.

## Operation
- call_in passes through a 2-flop synchronizer (always clocked) giving call_s.
- Capture: pending[i] <= pending[i] | call_s[i] each enabled cycle, except:
  - a call for car_floor while in DOOR is not latched and restarts the door timer;
  - in FAULT, capture is disabled.
- States: IDLE, MOVE, DOOR, FAULT.
- IDLE:
  - pending == 0 → stay.
  - pending[car_floor] set → DOOR; clear that bit.
  - otherwise select target T: if dir_pref = up and a call is above car_floor, T = nearest above; else if a call is below, T = nearest below (dir_pref <= down); else T = nearest above (dir_pref <= up).
  - Then go to MOVE: floor_cmd <= onehot(T), move timer <= 0.
- MOVE:
  - floor_cmd held; dir_up = (T > car_floor), dir_dn = (T < car_floor).
  - Retarget: a pending call strictly between car_floor and T in the travel direction replaces T. The timer is not reset.
  - car_floor == T → DOOR; clear pending[T]; floor_cmd <= 0.
  - timer == MOVE_TIMEOUT-1 without arrival → FAULT.
- DOOR: door_open = 1; count DOOR_CYCLES, then → IDLE. dir_pref is retained.
- FAULT: floor_cmd = 0, door_open = 0, dir_* = 0, fault = 1, pending cleared. Exit by reset only.
- Simultaneous arrival and timeout in the same cycle: arrival wins.
- Arrival check happens before capture: a call for T arriving in the arrival cycle is absorbed into the stop.

## Timing
- Reset values:
  - state = IDLE, dir_pref = up;
  - floor_cmd = 0, pending = 0, door_open = 0, dir_up = 0, dir_dn = 0, fault = 0;
  - synchronizers = 0.
- Latency from call_in rising to pending set: 3 enabled clk edges.
- Pending visible in IDLE at cycle N: floor_cmd or door_open is valid from cycle N+1 (registered outputs).
- car_floor == T sampled at edge K: door_open high from K+1 for exactly DOOR_CYCLES cycles (absent restarts), then at least one IDLE cycle.
- MOVE entered at edge M with no arrival: fault rises at edge M+MOVE_TIMEOUT.
- ena low mid-MOVE or mid-DOOR: timers and outputs freeze; operation resumes unchanged when ena returns.
- rst_n asserted mid-operation: all outputs go to reset values immediately (asynchronous). Deassertion is synchronous to clk.

## Structure
- Package elevator_pkg:
  - NUM_FLOORS = 4 and FLOOR_W = 2;
  - state enum {IDLE, MOVE, DOOR, FAULT};
  - onehot(floor) function.
  The position FSM and this block share it.
- Sub-module scan_target_sel: purely combinational. Inputs pending, car_floor, dir_pref, current target, in_move. Outputs target, target_valid, new dir_pref. This keeps the SCAN/retarget priority logic isolated for unit test.
- Top holds the synchronizer, pending register, FSM, move timer and door timer.

## Test plan
- Reset, car_floor = 0, pulse call_in = 0100 → pending = 0100 after 3 edges; next edge floor_cmd = 0100, dir_up = 1. Drive car_floor = 2 → door_open for 8 cycles, pending = 0000, floor_cmd = 0.
- car_floor = 1 idle, call_in = 0010 → no MOVE; DOOR directly, floor_cmd stays 0.
- dir_pref up, car_floor = 1, pending = 1001 → target 3 first (floor_cmd = 1000), then floor 0 (floor_cmd = 0001, dir_dn = 1).
- MOVE to 3 from 0, call floor 2 arrives while car_floor = 1 → floor_cmd switches to 0100. Car stops at 2, then resumes to 3.
- MOVE to 3 with car_floor held at 0 → fault = 1 exactly 64 cycles after MOVE entry. floor_cmd = 0, pending = 0. Further calls are ignored until rst_n.
- Door phase at floor 2, call_in = 0100 re-pressed at door cycle 5 → door_open extends to 5 + 8 cycles total; pending[2] stays 0.

Source files
------------

// File: rtl/elevator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elevator_pkg : shared floor constants, scheduler states, helpers      |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
package elevator_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        DOOR  = 2'd2,
        FAULT = 2'd3
    } state_e;

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] floor);
        logic [NUM_FLOORS-1:0] v;
        v        = '0;
        v[floor] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_target_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scan_target_sel : SCAN next-target and in-flight retarget selection   |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module scan_target_sel
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    car_floor,
    input  logic                  dir_pref,
    input  logic [FLOOR_W-1:0]    cur_target,
    input  logic                  in_move,
    output logic [FLOOR_W-1:0]    target,
    output logic                  target_valid,
    output logic                  dir_pref_nxt
);

    logic               above_found;
    logic [FLOOR_W-1:0] above_floor;
    logic               below_found;
    logic [FLOOR_W-1:0] below_floor;
    logic               btw_found;
    logic [FLOOR_W-1:0] btw_floor;
    logic               going_up;

    always_comb begin
        above_found = 1'b0;
        above_floor = '0;
        below_found = 1'b0;
        below_floor = '0;
        btw_found   = 1'b0;
        btw_floor   = '0;
        going_up    = (cur_target > car_floor);

        // Descending scan: the last hit is the call closest above the car.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(car_floor))) begin
                above_found = 1'b1;
                above_floor = FLOOR_W'(i);
                if (going_up && (i < int'(cur_target))) begin
                    btw_found = 1'b1;
                    btw_floor = FLOOR_W'(i);
                end
            end
        end

        // Ascending scan: the last hit is the call closest below the car.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(car_floor))) begin
                below_found = 1'b1;
                below_floor = FLOOR_W'(i);
                if (!going_up && (i > int'(cur_target))) begin
                    btw_found = 1'b1;
                    btw_floor = FLOOR_W'(i);
                end
            end
        end

        target       = cur_target;
        target_valid = 1'b0;
        dir_pref_nxt = dir_pref;

        if (in_move) begin
            target_valid = 1'b1;
            if (btw_found) begin
                target = btw_floor;
            end
        end else if (dir_pref && above_found) begin
            target       = above_floor;
            target_valid = 1'b1;
        end else if (below_found) begin
            target       = below_floor;
            target_valid = 1'b1;
            dir_pref_nxt = 1'b0;
        end else if (above_found) begin
            target       = above_floor;
            target_valid = 1'b1;
            dir_pref_nxt = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/elevator_call_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elevator_call_scheduler : call latch, SCAN dispatch, door/move timers |
// | Revision                : 1.0                                         |
// +----------------------------------------------------------------------+
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES  = 8,
    parameter int MOVE_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [NUM_FLOORS-1:0] call_in,
    input  logic [FLOOR_W-1:0]    car_floor,
    output logic [NUM_FLOORS-1:0] floor_cmd,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  dir_up,
    output logic                  dir_dn,
    output logic                  fault
);

    localparam int MOVE_W = $clog2(MOVE_TIMEOUT);
    localparam int DOOR_W = $clog2(DOOR_CYCLES);
    localparam logic [MOVE_W-1:0] MOVE_LAST = MOVE_W'(MOVE_TIMEOUT - 1);
    localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);

    logic [NUM_FLOORS-1:0] sync1_q, sync1_d;
    logic [NUM_FLOORS-1:0] call_s_q, call_s_d;
    state_e                state_q, state_d;
    logic                  dir_pref_q, dir_pref_d;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] floor_cmd_q, floor_cmd_d;
    logic                  door_open_q, door_open_d;
    logic                  dir_up_q, dir_up_d;
    logic                  dir_dn_q, dir_dn_d;
    logic                  fault_q, fault_d;
    logic [MOVE_W-1:0]     move_tmr_q, move_tmr_d;
    logic [DOOR_W-1:0]     door_tmr_q, door_tmr_d;

    logic [FLOOR_W-1:0]    sel_target;
    logic                  sel_valid;
    logic                  sel_dir_pref;

    scan_target_sel u_scan_target_sel (
        .pending      (pending_q),
        .car_floor    (car_floor),
        .dir_pref     (dir_pref_q),
        .cur_target   (target_q),
        .in_move      (state_q == MOVE),
        .target       (sel_target),
        .target_valid (sel_valid),
        .dir_pref_nxt (sel_dir_pref)
    );

    always_comb begin
        sync1_d     = call_in;
        call_s_d    = sync1_q;
        state_d     = state_q;
        dir_pref_d  = dir_pref_q;
        target_d    = target_q;
        pending_d   = pending_q;
        floor_cmd_d = floor_cmd_q;
        door_open_d = door_open_q;
        dir_up_d    = dir_up_q;
        dir_dn_d    = dir_dn_q;
        fault_d     = fault_q;
        move_tmr_d  = move_tmr_q;
        door_tmr_d  = door_tmr_q;

        if (ena) begin
            case (state_q)
                IDLE: begin
                    pending_d = pending_q | call_s_q;
                    if (pending_q[car_floor]) begin
                        pending_d[car_floor] = 1'b0;
                        state_d              = DOOR;
                        door_open_d          = 1'b1;
                        door_tmr_d           = '0;
                    end else if (sel_valid) begin
                        state_d     = MOVE;
                        target_d    = sel_target;
                        dir_pref_d  = sel_dir_pref;
                        floor_cmd_d = onehot(sel_target);
                        dir_up_d    = (sel_target > car_floor);
                        dir_dn_d    = (sel_target < car_floor);
                        move_tmr_d  = '0;
                    end
                end
                MOVE: begin
                    pending_d = pending_q | call_s_q;
                    // Arrival is tested first so it beats a same-cycle timeout
                    // and swallows a fresh call for the stop floor.
                    if (car_floor == target_q) begin
                        pending_d[target_q] = 1'b0;
                        state_d             = DOOR;
                        floor_cmd_d         = '0;
                        dir_up_d            = 1'b0;
                        dir_dn_d            = 1'b0;
                        door_open_d         = 1'b1;
                        door_tmr_d          = '0;
                    end else if (move_tmr_q == MOVE_LAST) begin
                        state_d     = FAULT;
                        pending_d   = '0;
                        floor_cmd_d = '0;
                        dir_up_d    = 1'b0;
                        dir_dn_d    = 1'b0;
                        fault_d     = 1'b1;
                    end else begin
                        move_tmr_d  = move_tmr_q + MOVE_W'(1);
                        target_d    = sel_target;
                        floor_cmd_d = onehot(sel_target);
                        dir_up_d    = (sel_target > car_floor);
                        dir_dn_d    = (sel_target < car_floor);
                    end
                end
                DOOR: begin
                    pending_d = pending_q | (call_s_q & ~onehot(car_floor));
                    if (call_s_q[car_floor]) begin
                        door_tmr_d = '0;
                    end else if (door_tmr_q == DOOR_LAST) begin
                        state_d     = IDLE;
                        door_open_d = 1'b0;
                    end else begin
                        door_tmr_d = door_tmr_q + DOOR_W'(1);
                    end
                end
                default: begin
                    pending_d   = '0;
                    floor_cmd_d = '0;
                    door_open_d = 1'b0;
                    dir_up_d    = 1'b0;
                    dir_dn_d    = 1'b0;
                    fault_d     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            call_s_q    <= '0;
            state_q     <= IDLE;
            dir_pref_q  <= 1'b1;
            target_q    <= '0;
            pending_q   <= '0;
            floor_cmd_q <= '0;
            door_open_q <= 1'b0;
            dir_up_q    <= 1'b0;
            dir_dn_q    <= 1'b0;
            fault_q     <= 1'b0;
            move_tmr_q  <= '0;
            door_tmr_q  <= '0;
        end else begin
            sync1_q     <= sync1_d;
            call_s_q    <= call_s_d;
            state_q     <= state_d;
            dir_pref_q  <= dir_pref_d;
            target_q    <= target_d;
            pending_q   <= pending_d;
            floor_cmd_q <= floor_cmd_d;
            door_open_q <= door_open_d;
            dir_up_q    <= dir_up_d;
            dir_dn_q    <= dir_dn_d;
            fault_q     <= fault_d;
            move_tmr_q  <= move_tmr_d;
            door_tmr_q  <= door_tmr_d;
        end
    end

    assign floor_cmd = floor_cmd_q;
    assign pending   = pending_q;
    assign door_open = door_open_q;
    assign dir_up    = dir_up_q;
    assign dir_dn    = dir_dn_q;
    assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_call_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_elevator_call_scheduler : directed + random bench with ref model   |
// | Revision                   : 1.0                                      |
// +----------------------------------------------------------------------+
module tb_elevator_call_scheduler;

    localparam int DOOR_CYCLES  = 8;
    localparam int MOVE_TIMEOUT = 64;
    localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2, M_FAULT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [3:0] call_in = 4'b0;
    logic [1:0] car_floor = 2'd0;
    logic [3:0] floor_cmd;
    logic [3:0] pending;
    logic       door_open;
    logic       dir_up;
    logic       dir_dn;
    logic       fault;

    elevator_call_scheduler #(
        .DOOR_CYCLES  (DOOR_CYCLES),
        .MOVE_TIMEOUT (MOVE_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .call_in   (call_in),
        .car_floor (car_floor),
        .floor_cmd (floor_cmd),
        .pending   (pending),
        .door_open (door_open),
        .dir_up    (dir_up),
        .dir_dn    (dir_dn),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode, call set, target floor, age in motion, door cycles left.
    int       m_mode;
    logic [3:0] m_pend;
    int       m_tgt;
    logic     m_up;
    int       m_age;
    int       m_left;
    logic [3:0] m_cmd;
    logic     m_door, m_du, m_dd, m_fault;
    logic [3:0] m_s1, m_s2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_pend = 4'b0; m_tgt = 0; m_up = 1'b1;
        m_age = 0; m_left = 0; m_cmd = 4'b0;
        m_door = 1'b0; m_du = 1'b0; m_dd = 1'b0; m_fault = 1'b0;
        m_s1 = 4'b0; m_s2 = 4'b0;
    endtask

    task automatic model_step();
        logic [3:0] cs, p, np;
        int cf, t, stp, above, below;
        cs = m_s2; m_s2 = m_s1; m_s1 = call_in;
        if (!ena) return;
        cf = int'(car_floor);
        p  = m_pend;
        np = p | cs;
        case (m_mode)
            M_IDLE: begin
                if (p[cf]) begin
                    np[cf] = 1'b0; m_mode = M_DOOR; m_left = DOOR_CYCLES; m_door = 1'b1;
                end else if (p != 4'b0) begin
                    above = -1; below = -1;
                    for (int d = 3; d >= 1; d--) begin
                        if (cf + d <= 3 && p[cf + d]) above = cf + d;
                        if (cf - d >= 0 && p[cf - d]) below = cf - d;
                    end
                    if (m_up && above >= 0) t = above;
                    else if (below >= 0) begin t = below; m_up = 1'b0; end
                    else begin t = above; m_up = 1'b1; end
                    m_tgt = t; m_mode = M_MOVE; m_age = 0;
                    m_cmd = 4'b0001 << t; m_du = (t > cf); m_dd = (t < cf);
                end
            end
            M_MOVE: begin
                if (cf == m_tgt) begin
                    np[m_tgt] = 1'b0; m_mode = M_DOOR; m_left = DOOR_CYCLES; m_door = 1'b1;
                    m_cmd = 4'b0; m_du = 1'b0; m_dd = 1'b0;
                end else if (m_age == MOVE_TIMEOUT - 1) begin
                    m_mode = M_FAULT; np = 4'b0; m_cmd = 4'b0;
                    m_du = 1'b0; m_dd = 1'b0; m_fault = 1'b1;
                end else begin
                    m_age++;
                    stp = (m_tgt > cf) ? 1 : -1;
                    for (int f = cf + stp; f != m_tgt; f += stp) begin
                        if (p[f]) begin m_tgt = f; break; end
                    end
                    m_cmd = 4'b0001 << m_tgt; m_du = (m_tgt > cf); m_dd = (m_tgt < cf);
                end
            end
            M_DOOR: begin
                np = p | (cs & ~(4'b0001 << cf));
                if (cs[cf]) m_left = DOOR_CYCLES;
                else if (m_left == 1) begin m_mode = M_IDLE; m_door = 1'b0; end
                else m_left--;
            end
            default: np = 4'b0;
        endcase
        m_pend = np;
    endtask

    task automatic check_all();
        chk("floor_cmd", floor_cmd, m_cmd);
        chk("pending", pending, m_pend);
        chk("door_open", door_open, m_door);
        chk("dir_up", dir_up, m_du);
        chk("dir_dn", dir_dn, m_dd);
        chk("fault", fault, m_fault);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic press(input logic [3:0] mask);
        call_in = mask; tick();
        call_in = 4'b0; tick();
        tick();
    endtask

    // Counts door-open cycles; optionally re-presses 'mask' during door cycle press_at.
    task automatic run_door(input int press_at, input logic [3:0] mask, output int n);
        n = 0;
        for (int g = 0; g < 40 && door_open; g++) begin
            n++;
            if (n == press_at) call_in = mask;
            if (n == press_at + 1) call_in = 4'b0;
            tick();
        end
        call_in = 4'b0;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_floor_cmd", floor_cmd, 4'b0);
        chk("arst_pending", pending, 4'b0);
        chk("arst_door", door_open, 1'b0);
        chk("arst_dirs", {dir_up, dir_dn}, 2'b00);
        chk("arst_fault", fault, 1'b0);
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_floor_cmd", floor_cmd, 4'b0);
        chk("rst_pending", pending, 4'b0);
        chk("rst_door", door_open, 1'b0);
        chk("rst_fault", fault, 1'b0);

        // Basic trip 0 -> 2
        press(4'b0100);
        chk("t1_pending", pending, 4'b0100);
        tick();
        chk("t1_cmd", floor_cmd, 4'b0100);
        chk("t1_up", dir_up, 1'b1);
        car_floor = 2'd2; tick();
        chk("t1_door", door_open, 1'b1);
        chk("t1_cmd_clr", floor_cmd, 4'b0);
        chk("t1_pend_clr", pending, 4'b0);
        run_door(0, 4'b0, n);
        chk("t1_door_len", n, DOOR_CYCLES);

        // Call at current floor opens door directly
        car_floor = 2'd1;
        press(4'b0010);
        chk("t2_pending", pending, 4'b0010);
        tick();
        chk("t2_door", door_open, 1'b1);
        chk("t2_cmd", floor_cmd, 4'b0);
        run_door(0, 4'b0, n);
        chk("t2_door_len", n, DOOR_CYCLES);

        // SCAN: up-preference serves 3 before 0
        press(4'b1001);
        chk("t3_pending", pending, 4'b1001);
        tick();
        chk("t3_cmd_up", floor_cmd, 4'b1000);
        chk("t3_up", dir_up, 1'b1);
        car_floor = 2'd2; tick();
        car_floor = 2'd3; tick();
        chk("t3_door3", door_open, 1'b1);
        chk("t3_pend_left", pending, 4'b0001);
        run_door(0, 4'b0, n);
        tick();
        chk("t3_cmd_dn", floor_cmd, 4'b0001);
        chk("t3_dn", dir_dn, 1'b1);
        car_floor = 2'd2; tick();
        car_floor = 2'd1; tick();
        car_floor = 2'd0; tick();
        chk("t3_door0", door_open, 1'b1);
        run_door(0, 4'b0, n);

        // Retarget to an intermediate call during travel
        press(4'b1000);
        tick();
        chk("t4_cmd", floor_cmd, 4'b1000);
        car_floor = 2'd1; tick();
        press(4'b0100);
        tick();
        chk("t4_retarget", floor_cmd, 4'b0100);
        car_floor = 2'd2; tick();
        chk("t4_door2", door_open, 1'b1);
        chk("t4_pend", pending, 4'b1000);
        run_door(0, 4'b0, n);
        tick();
        chk("t4_resume", floor_cmd, 4'b1000);
        car_floor = 2'd3; tick();
        chk("t4_door3", door_open, 1'b1);
        run_door(0, 4'b0, n);

        // Move timeout
        car_floor = 2'd0;
        press(4'b1000);
        tick();
        chk("t5_cmd", floor_cmd, 4'b1000);
        for (int k = 1; k <= MOVE_TIMEOUT; k++) begin
            tick();
            chk("t5_fault_edge", fault, (k == MOVE_TIMEOUT));
        end
        chk("t5_cmd_clr", floor_cmd, 4'b0);
        chk("t5_pend_clr", pending, 4'b0);
        press(4'b0010);
        tick();
        chk("t5_ignored", pending, 4'b0);
        chk("t5_sticky", fault, 1'b1);
        async_reset();

        // Door restart by re-press of the stop floor
        car_floor = 2'd2;
        press(4'b0100);
        tick();
        chk("t6_door", door_open, 1'b1);
        run_door(5 - 2, 4'b0100, n);
        chk("t6_door_len", n, 5 + DOOR_CYCLES);
        chk("t6_pend", pending, 4'b0);

        // Clock-enable freeze mid-move
        press(4'b0001);
        tick();
        chk("t7_cmd", floor_cmd, 4'b0001);
        chk("t7_dn", dir_dn, 1'b1);
        ena = 1'b0; car_floor = 2'd0;
        repeat (5) begin
            tick();
            chk("t7_hold_cmd", floor_cmd, 4'b0001);
            chk("t7_hold_door", door_open, 1'b0);
        end
        ena = 1'b1; tick();
        chk("t7_door", door_open, 1'b1);
        run_door(0, 4'b0, n);
        chk("t7_door_len", n, DOOR_CYCLES);

        // Async reset mid-move
        press(4'b1000);
        tick();
        chk("t8_cmd", floor_cmd, 4'b1000);
        async_reset();

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if (c % 700 == 699) begin
                async_reset();
            end else begin
                ena     = ($urandom_range(0, 7) != 0);
                call_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
                if (m_cmd != 4'b0 && !((c % 700) >= 200 && (c % 700) < 330)
                    && $urandom_range(0, 2) == 0) begin
                    if (m_tgt > int'(car_floor)) car_floor = car_floor + 2'd1;
                    else if (m_tgt < int'(car_floor)) car_floor = car_floor - 2'd1;
                end
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
